// File: rtl/draw_text_box.sv
// draw_text_box: text overlay stage for the VGA draw pipeline.
// Each pixel asks the text ROM for its character. The returned code and the
// glyph line form a font ROM address. The glyph bit then paints FG_COLOR into
// the RGB stream. The timing bus is delayed so it stays aligned with rgb_out.
// Optional feature macro: TXT_BG_EN. When defined, non-glyph pixels inside the
// box are painted BG_COLOR, giving an opaque box. When undefined, those pixels
// pass rgb_in through unchanged, giving transparent text.
module draw_text_box #(
    parameter logic [10:0] TXT_X    = 11'd0,
    parameter logic [10:0] TXT_Y    = 11'd0,
    parameter int          COLS     = 16,
    parameter int          ROWS     = 1,
    parameter logic [11:0] FG_COLOR = 12'hFFF,
    parameter logic [11:0] BG_COLOR = 12'h000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    output logic [7:0]  char_xy,
    input  logic [6:0]  char_code,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_data,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

`ifdef TXT_BG_EN
    localparam bit BG_EN = 1'b1;
`else
    localparam bit BG_EN = 1'b0;
`endif

    // Far box edges (exclusive), one bit wider so they cannot overflow.
    localparam logic [11:0] X_END = 12'(TXT_X) + 12'(8 * COLS);
    localparam logic [11:0] Y_END = 12'(TXT_Y) + 12'(16 * ROWS);

    logic [6:0]  rel_x;
    logic [7:0]  rel_y;
    logic        in_box;

    logic [3:0]  line_d1, line_d2;
    logic [2:0]  xoff_d1, xoff_d2, xoff_d3;
    logic        in_box_d1, in_box_d2, in_box_d3;

    logic [10:0] hc_d [4];
    logic [10:0] vc_d [4];
    logic        hs_d [4];
    logic        vs_d [4];
    logic        hb_d [4];
    logic        vb_d [4];
    logic [11:0] rgb_d [3];

    // Only the low bits of the offsets are needed. Membership is decided on
    // the raw coordinates, so a pixel left of or above the box cannot wrap
    // into it.
    always_comb begin
        rel_x  = hcount_in[6:0] - TXT_X[6:0];
        rel_y  = vcount_in[7:0] - TXT_Y[7:0];
        in_box = (hcount_in >= TXT_X) && ({1'b0, hcount_in} < X_END) &&
                 (vcount_in >= TXT_Y) && ({1'b0, vcount_in} < Y_END);
    end

    // The text ROM has registered char_code by now, so it lines up with line_d2.
    assign font_addr = {char_code, line_d2};

    // Stages 1-3: text ROM index, plus cell line/column and box flag that ride alongside the ROM reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            char_xy   <= 8'h00;
            line_d1   <= 4'd0;
            line_d2   <= 4'd0;
            xoff_d1   <= 3'd0;
            xoff_d2   <= 3'd0;
            xoff_d3   <= 3'd0;
            in_box_d1 <= 1'b0;
            in_box_d2 <= 1'b0;
            in_box_d3 <= 1'b0;
        end else begin
            char_xy   <= in_box ? {rel_y[7:4], rel_x[6:3]} : 8'h00;
            line_d1   <= rel_y[3:0];
            xoff_d1   <= rel_x[2:0];
            in_box_d1 <= in_box;
            line_d2   <= line_d1;
            xoff_d2   <= xoff_d1;
            in_box_d2 <= in_box_d1;
            xoff_d3   <= xoff_d2;
            in_box_d3 <= in_box_d2;
        end
    end

    // Four-deep delay of the timing bus; the rgb line is three deep because the paint register is its last tap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                hc_d[i] <= 11'd0;
                vc_d[i] <= 11'd0;
                hs_d[i] <= 1'b0;
                vs_d[i] <= 1'b0;
                hb_d[i] <= 1'b0;
                vb_d[i] <= 1'b0;
            end
            for (int i = 0; i < 3; i++) rgb_d[i] <= 12'h000;
        end else begin
            hc_d[0]  <= hcount_in;
            vc_d[0]  <= vcount_in;
            hs_d[0]  <= hsync_in;
            vs_d[0]  <= vsync_in;
            hb_d[0]  <= hblnk_in;
            vb_d[0]  <= vblnk_in;
            rgb_d[0] <= rgb_in;
            for (int i = 1; i < 4; i++) begin
                hc_d[i] <= hc_d[i-1];
                vc_d[i] <= vc_d[i-1];
                hs_d[i] <= hs_d[i-1];
                vs_d[i] <= vs_d[i-1];
                hb_d[i] <= hb_d[i-1];
                vb_d[i] <= vb_d[i-1];
            end
            for (int i = 1; i < 3; i++) rgb_d[i] <= rgb_d[i-1];
        end
    end

    // Stage 4: paint. Blanking wins, then the glyph bit, then the optional box background.
    // ~xoff_d3 equals 7 - xoff_d3, because the font MSB is the leftmost pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_out <= 12'h000;
        end else if (hb_d[2] || vb_d[2]) begin
            rgb_out <= 12'h000;
        end else if (in_box_d3 && font_data[~xoff_d3]) begin
            rgb_out <= FG_COLOR;
        end else if (in_box_d3 && BG_EN) begin
            rgb_out <= BG_COLOR;
        end else begin
            rgb_out <= rgb_d[2];
        end
    end

    assign hcount_out = hc_d[3];
    assign vcount_out = vc_d[3];
    assign hsync_out  = hs_d[3];
    assign vsync_out  = vs_d[3];
    assign hblnk_out  = hb_d[3];
    assign vblnk_out  = vb_d[3];

endmodule

// File: tb/tb_draw_text_box.sv
// Testbench for draw_text_box: a 100,50 box with 16x2 cells, plus behavioural text and font ROMs.
// Expected outputs come from pixel-geometry arithmetic in the bench.
module tb_draw_text_box;

    localparam int X0 = 100;
    localparam int Y0 = 50;
    localparam int NC = 16;
    localparam int NR = 2;
    localparam logic [11:0] FG = 12'hFFF;
    localparam logic [11:0] BG = 12'h123;
`ifdef TXT_BG_EN
    localparam bit BGON = 1'b1;
`else
    localparam bit BGON = 1'b0;
`endif
    localparam logic [11:0] PASS_RGB = 12'h0A0;
    localparam logic [11:0] INBOX_BACK = BGON ? BG : PASS_RGB;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] hcount_in = '0, vcount_in = '0;
    logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
    logic [11:0] rgb_in = '0;
    logic [7:0]  char_xy;
    logic [6:0]  char_code = '0;
    logic [10:0] font_addr;
    logic [7:0]  font_data = '0;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;

    logic [6:0] text_mem [256];
    logic [7:0] font_mem [2048];

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0]  cxy;
        logic [10:0] hc;
        logic [10:0] vc;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic [11:0] rgb;
    } exp_t;

    exp_t hist[$];

    draw_text_box #(
        .TXT_X(11'd100), .TXT_Y(11'd50), .COLS(NC), .ROWS(NR),
        .FG_COLOR(FG), .BG_COLOR(BG)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in),
        .char_xy(char_xy), .char_code(char_code),
        .font_addr(font_addr), .font_data(font_data),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out),
        .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out)
    );

    always #5 clk = ~clk;

    // Synchronous ROMs with one cycle of read latency.
    always @(posedge clk) begin
        char_code <= text_mem[char_xy];
        font_data <= font_mem[font_addr];
    end

    // What a pixel must look like, worked out from box geometry and the ROM contents.
    function automatic exp_t model(input int h, input int v, input logic hs, input logic vs,
                                   input logic hb, input logic vb, input logic [11:0] rgb);
        exp_t e;
        int idx;
        logic [6:0] ch;
        logic [7:0] row;
        e.cxy = 8'h00;
        e.hc = 11'(h);
        e.vc = 11'(v);
        e.hs = hs;
        e.vs = vs;
        e.hb = hb;
        e.vb = vb;
        e.rgb = rgb;
        if (h >= X0 && h < X0 + 8 * NC && v >= Y0 && v < Y0 + 16 * NR) begin
            idx = ((v - Y0) / 16) * 16 + (h - X0) / 8;
            e.cxy = 8'(idx);
            ch = text_mem[idx];
            row = font_mem[int'(ch) * 16 + (v - Y0) % 16];
            if (row[7 - (h - X0) % 8]) e.rgb = FG;
            else if (BGON) e.rgb = BG;
        end
        if (hb || vb) e.rgb = 12'h000;
        return e;
    endfunction

    // Record what every sampled input must produce; a cycle in reset yields all zeros.
    always @(posedge clk) begin
        if (rst_n)
            hist.push_back(model(int'(hcount_in), int'(vcount_in), hsync_in, vsync_in,
                                 hblnk_in, vblnk_in, rgb_in));
        else
            hist.push_back('0);
        if (hist.size() > 8) void'(hist.pop_front());
    end

    // Per-cycle compare: char_xy belongs to this edge's input; the bus belongs to the input three edges back.
    always @(posedge clk) begin
        exp_t want, got;
        #1;
        if (!rst_n) want = '0;
        else if (hist.size() >= 4) begin
            want = hist[hist.size() - 4];
            want.cxy = hist[hist.size() - 1].cxy;
        end else want = '0;
        got = {char_xy, hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out};
        checks++;
        if (got.cxy !== want.cxy) begin
            errors++;
            $display("FAIL char_xy t=%0t got %h want %h", $time, got.cxy, want.cxy);
        end
        checks++;
        if (got[37:0] !== want[37:0]) begin
            errors++;
            $display("FAIL bus t=%0t got hc=%0d vc=%0d s=%b%b b=%b%b rgb=%h want hc=%0d vc=%0d s=%b%b b=%b%b rgb=%h",
                     $time, got.hc, got.vc, got.hs, got.vs, got.hb, got.vb, got.rgb,
                     want.hc, want.vc, want.hs, want.vs, want.hb, want.vb, want.rgb);
        end
    end

    task automatic lit(input string nm, input logic [11:0] got, input logic [11:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, got, want);
        end
    endtask

    // Hold one pixel for four cycles and pin char_xy and rgb_out to hand-worked values.
    task automatic dir(input string nm, input int h, input int v, input logic hb,
                       input logic [7:0] want_cxy, input logic [11:0] want_rgb);
        @(negedge clk);
        hcount_in = 11'(h);
        vcount_in = 11'(v);
        hblnk_in = hb;
        vblnk_in = 1'b0;
        rgb_in = PASS_RGB;
        @(posedge clk);
        #1;
        lit({nm, "_cxy"}, {4'h0, char_xy}, {4'h0, want_cxy});
        repeat (3) @(posedge clk);
        #1;
        lit({nm, "_rgb"}, rgb_out, want_rgb);
        lit({nm, "_hc"}, {1'b0, hcount_out}, 12'(h));
    endtask

    task automatic rand_pixel();
        @(negedge clk);
        if ($urandom_range(0, 9) == 0) hcount_in = 11'($urandom_range(0, 2047));
        else hcount_in = 11'($urandom_range(90, 240));
        vcount_in = 11'($urandom_range(40, 90));
        hsync_in = 1'($urandom);
        vsync_in = 1'($urandom);
        hblnk_in = ($urandom_range(0, 7) == 0);
        vblnk_in = ($urandom_range(0, 7) == 0);
        rgb_in = 12'($urandom);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            rand_pixel();
            @(posedge clk);
            #1;
            lit("rst_cxy", {4'h0, char_xy}, 12'h000);
            lit("rst_rgb", rgb_out, 12'h000);
            lit("rst_tim", {6'h0, hsync_out, vsync_out, hblnk_out, vblnk_out, 2'b00},
                12'h000);
            lit("rst_hc", {1'b0, hcount_out}, 12'h000);
        end
        @(negedge clk);
        hcount_in = '0;
        vcount_in = '0;
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) text_mem[i] = 7'($urandom);
        for (int i = 0; i < 2048; i++) font_mem[i] = 8'($urandom);
        text_mem[8'h00] = 7'h67;
        text_mem[8'h0F] = 7'h20;
        text_mem[8'h10] = 7'h20;
        for (int i = 0; i < 16; i++) font_mem[{7'h20, 4'(i)}] = 8'h00;
        font_mem[{7'h67, 4'd0}] = 8'h80;

        do_reset(6);
        repeat (2) @(negedge clk);

        dir("glyph_100_50", 100, 50, 1'b0, 8'h00, FG);
        dir("col15_227_65", 227, 65, 1'b0, 8'h0F, INBOX_BACK);
        dir("row1_100_66", 100, 66, 1'b0, 8'h10, INBOX_BACK);
        dir("right_228_50", 228, 50, 1'b0, 8'h00, PASS_RGB);
        dir("bg_101_50", 101, 50, 1'b0, 8'h00, INBOX_BACK);
        dir("blank_100_50", 100, 50, 1'b1, 8'h00, 12'h000);
        dir("left_99_50", 99, 50, 1'b0, 8'h00, PASS_RGB);
        dir("wrap_0_50", 0, 50, 1'b0, 8'h00, PASS_RGB);

        for (int i = 0; i < 1500; i++) rand_pixel();
        do_reset(5);
        for (int i = 0; i < 1000; i++) rand_pixel();
        repeat (6) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
